branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating-counter BHT with ID/EX prediction tracking.
// Define BP_PERF_CNT_EN to build the branch and mispredict performance counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module branch_predictor #(
  parameter int unsigned BHT_DEPTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   if_valid_i,
  input  logic [`DATA_WIDTH-1:0] if_pc_i,
  input  logic                   stall_i,
  input  logic                   ex_branch_i,
  input  logic                   ex_taken_i,
  input  logic [`DATA_WIDTH-1:0] ex_target_i,
  output logic                   pred_taken_o,
  output logic                   mispredict_o,
  output logic [`DATA_WIDTH-1:0] redirect_pc_o,
  output logic [31:0]            branch_cnt_o,
  output logic [31:0]            mispred_cnt_o
);

  localparam int unsigned Idx = $clog2(BHT_DEPTH);

  typedef logic [`DATA_WIDTH-1:0] pc_t;

  logic [1:0]     bht_q [BHT_DEPTH];
  logic           id_valid_q, ex_valid_q;
  pc_t            id_pc_q, ex_pc_q;
  logic           id_pred_q, ex_pred_q;
  logic [Idx-1:0] if_idx, ex_idx;
  logic [1:0]     cnt_cur, cnt_nxt;
  logic           bht_upd;

  assign if_idx  = if_pc_i[Idx+1:2];
  assign ex_idx  = ex_pc_q[Idx+1:2];
  assign cnt_cur = bht_q[ex_idx];
  assign bht_upd = ex_valid_q & ex_branch_i & ~stall_i;

  always_comb begin
    pred_taken_o  = if_valid_i & bht_q[if_idx][1];
    mispredict_o  = ex_valid_q & ex_branch_i & (ex_taken_i != ex_pred_q);
    redirect_pc_o = '0;
    if (mispredict_o) begin
      redirect_pc_o = ex_taken_i ? ex_target_i : ex_pc_q + pc_t'(4);
    end
  end

  always_comb begin
    cnt_nxt = cnt_cur;
    if (ex_taken_i) begin
      if (cnt_cur != 2'b11) cnt_nxt = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_nxt = cnt_cur - 2'b01;
    end
  end

  // A mispredict squashes both younger slots; a stall freezes the whole tracking pipe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_pred_q  <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_pred_q  <= 1'b0;
    end else if (!stall_i) begin
      id_valid_q <= if_valid_i & ~mispredict_o;
      id_pc_q    <= if_pc_i;
      id_pred_q  <= pred_taken_o;
      ex_valid_q <= id_valid_q & ~mispredict_o;
      ex_pc_q    <= id_pc_q;
      ex_pred_q  <= id_pred_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (bht_upd) begin
      bht_q[ex_idx] <= cnt_nxt;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (bht_upd) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict_o) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule
